// File: rtl/wfunc_out_scaler_if.sv
// Stream and APB signal bundle for the window-function output scaler.
// The slave modport is the scaler's view; master is the view of its environment.
interface wfunc_out_scaler_if #(
    parameter int BUS_NUM = 2,
    parameter int APB_AW  = 4
);
    logic                            in_tvalid;
    logic                            in_tready;
    logic                            in_tlast;
    logic [BUS_NUM-1:0][1:0][31:0]   in_tdata;
    logic                            out_tvalid;
    logic                            out_tready;
    logic                            out_tlast;
    logic [BUS_NUM-1:0][1:0][15:0]   out_tdata;
    logic                            psel;
    logic                            penable;
    logic                            pwrite;
    logic [APB_AW-1:0]               paddr;
    logic [31:0]                     pwdata;
    logic [31:0]                     prdata;

    modport slave (
        input  in_tvalid, in_tlast, in_tdata, out_tready,
        input  psel, penable, pwrite, paddr, pwdata,
        output in_tready, out_tvalid, out_tlast, out_tdata, prdata
    );

    modport master (
        output in_tvalid, in_tlast, in_tdata, out_tready,
        output psel, penable, pwrite, paddr, pwdata,
        input  in_tready, out_tvalid, out_tlast, out_tdata, prdata
    );
endinterface

// File: rtl/wfunc_out_scaler.sv
// Rescales 32-bit complex window products to 16-bit samples: rounding arithmetic
// right shift, then saturation; shift is latched per packet, two-stage pipeline.
module wfunc_out_scaler #(
    parameter int BUS_NUM = 2,
    parameter int APB_AW  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wfunc_out_scaler_if.slave     bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_e;

    localparam logic [APB_AW-1:0] ADDR_CONFIG = APB_AW'(32'h0);
    localparam logic [APB_AW-1:0] ADDR_SAT    = APB_AW'(32'h4);
    localparam logic [APB_AW-1:0] ADDR_STATUS = APB_AW'(32'h8);

    // Sign-extend to 33 bits so adding the half-LSB rounding term cannot overflow.
    function automatic logic [32:0] round_shift(input logic [31:0] x, input logic [4:0] s);
        logic signed [32:0] rnd;
        logic signed [32:0] r;
        rnd = (s == 5'd0) ? 33'sd0 : (33'sd1 <<< (s - 5'd1));
        r   = $signed({x[31], x}) + rnd;
        return r >>> s;
    endfunction

    function automatic logic is_sat(input logic [32:0] v);
        return ($signed(v) > 33'sd32767) || ($signed(v) < -33'sd32768);
    endfunction

    function automatic logic [15:0] sat16(input logic [32:0] v);
        logic [15:0] res;
        if ($signed(v) > 33'sd32767) begin
            res = 16'h7FFF;
        end else if ($signed(v) < -33'sd32768) begin
            res = 16'h8000;
        end else begin
            res = v[15:0];
        end
        return res;
    endfunction

    state_e                          state_r;
    state_e                          state_nxt_s;
    logic [4:0]                      shift_r;
    logic [4:0]                      shift_act_r;
    logic [4:0]                      shift_use_s;
    logic                            load_act_s;
    logic                            en_s;
    logic                            accept_s;
    logic                            cfg_wr_s;
    logic                            cnt_clr_s;
    logic                            pkt_done_s;
    logic [BUS_NUM-1:0][1:0][32:0]   s1_calc_s;
    logic [BUS_NUM-1:0][1:0][32:0]   s1_data_r;
    logic                            s1_valid_r;
    logic                            s1_last_r;
    logic                            s1_sat_s;
    logic [BUS_NUM-1:0][1:0][15:0]   s2_calc_s;
    logic [BUS_NUM-1:0][1:0][15:0]   s2_data_r;
    logic                            s2_valid_r;
    logic                            s2_last_r;
    logic                            s2_sat_r;
    logic [31:0]                     sat_cnt_r;
    logic [23:0]                     pkt_cnt_r;
    logic [31:0]                     prdata_s;
    logic                            unused_s;

    assign en_s       = ~s2_valid_r | bus.out_tready;
    assign accept_s   = bus.in_tvalid & en_s;
    assign cfg_wr_s   = bus.psel & ~bus.penable & bus.pwrite & (bus.paddr == ADDR_CONFIG);
    assign cnt_clr_s  = cfg_wr_s & bus.pwdata[31];
    assign pkt_done_s = s2_valid_r & bus.out_tready & s2_last_r;

    assign bus.in_tready  = en_s;
    assign bus.out_tvalid = s2_valid_r;
    assign bus.out_tlast  = s2_last_r;
    assign bus.out_tdata  = s2_data_r;
    assign bus.prdata     = prdata_s;
    assign unused_s       = ^{bus.pwdata[30:5], s2_sat_r};

    // Packet FSM next state; the first beat of a packet loads the active shift.
    always_comb begin
        state_nxt_s = state_r;
        load_act_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    load_act_s  = 1'b1;
                    state_nxt_s = bus.in_tlast ? ST_IDLE : ST_PKT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PKT: begin
                if (accept_s && bus.in_tlast) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PKT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // A packet-start beat bypasses shift_act and uses the live CONFIG value.
    always_comb begin
        if (state_r == ST_IDLE) begin
            shift_use_s = shift_r;
        end else begin
            shift_use_s = shift_act_r;
        end
    end

    // Stage 1 datapath: round and shift every component.
    always_comb begin
        s1_calc_s = '0;
        for (int l = 0; l < BUS_NUM; l++) begin
            for (int c = 0; c < 2; c++) begin
                s1_calc_s[l][c] = round_shift(bus.in_tdata[l][c], shift_use_s);
            end
        end
    end

    // Stage 2 datapath: clamp to 16 bits and flag any clamp in the beat.
    always_comb begin
        s2_calc_s = '0;
        s1_sat_s  = 1'b0;
        for (int l = 0; l < BUS_NUM; l++) begin
            for (int c = 0; c < 2; c++) begin
                s2_calc_s[l][c] = sat16(s1_data_r[l][c]);
                s1_sat_s        = s1_sat_s | is_sat(s1_data_r[l][c]);
            end
        end
    end

    // APB register readback, combinational from the address.
    always_comb begin
        prdata_s = 32'd0;
        case (bus.paddr)
            ADDR_CONFIG: prdata_s = {27'd0, shift_r};
            ADDR_SAT:    prdata_s = sat_cnt_r;
            ADDR_STATUS: prdata_s = {pkt_cnt_r, 7'd0, (state_r == ST_PKT)};
            default:     prdata_s = 32'd0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // CONFIG shift field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= 5'd0;
        end else if (cfg_wr_s) begin
            shift_r <= bus.pwdata[4:0];
        end
    end

    // Per-packet shift latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_act_r <= 5'd0;
        end else if (load_act_s) begin
            shift_act_r <= shift_r;
        end
    end

    // Pipeline stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_data_r  <= '0;
        end else if (en_s) begin
            s1_valid_r <= accept_s;
            s1_last_r  <= bus.in_tlast;
            s1_data_r  <= s1_calc_s;
        end
    end

    // Pipeline stage 2 register, driving the output stream directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_data_r  <= '0;
            s2_sat_r   <= 1'b0;
        end else if (en_s) begin
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_last_r;
            s2_data_r  <= s2_calc_s;
            s2_sat_r   <= s1_sat_s;
        end
    end

    // Saturated-beat counter; a clear beats a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_r <= 32'd0;
        end else if (cnt_clr_s) begin
            sat_cnt_r <= 32'd0;
        end else if (en_s && s1_valid_r && s1_sat_s && (sat_cnt_r != 32'hFFFF_FFFF)) begin
            sat_cnt_r <= sat_cnt_r + 32'd1;
        end
    end

    // Completed-packet counter, wraps at 24 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_r <= 24'd0;
        end else if (cnt_clr_s) begin
            pkt_cnt_r <= 24'd0;
        end else if (pkt_done_s) begin
            pkt_cnt_r <= pkt_cnt_r + 24'd1;
        end
    end

endmodule

// File: tb/tb_wfunc_out_scaler.sv
// Randomized scoreboard bench for wfunc_out_scaler; expected beats come from an
// arithmetic model of round/shift/clamp with the per-packet shift rule.
module tb_wfunc_out_scaler;
    localparam int NB = 2;
    localparam int AW = 4;

    typedef logic [NB-1:0][1:0][31:0] idata_t;
    typedef logic [NB-1:0][1:0][15:0] odata_t;
    typedef struct {
        odata_t d;
        logic   last;
        int     cyc;
        bit     lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wfunc_out_scaler_if #(.BUS_NUM(NB), .APB_AW(AW)) bus ();
    wfunc_out_scaler #(.BUS_NUM(NB), .APB_AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t   sbq[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     acc_cnt = 0;
    int     rdy_mode = 1;
    bit     lat_chk = 0;
    int     m_shift = 0;
    int     m_act = 0;
    bit     m_in_pkt = 0;
    longint m_sat = 0;
    int     m_pkt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: floor((x + half) / 2^s) computed in wide integers, then clamp.
    function automatic int model_comp(input logic [31:0] x, input int s, output bit sat);
        longint r;
        longint y;
        r = longint'($signed(x));
        if (s > 0) r = r + (longint'(1) << (s - 1));
        y = r >>> s;
        sat = 1'b0;
        if (y > 32767) begin
            sat = 1'b1;
            y = 32767;
        end else if (y < -32768) begin
            sat = 1'b1;
            y = -32768;
        end
        return int'(y);
    endfunction

    function automatic odata_t model_beat(input idata_t d, input int s, output bit sat);
        odata_t o;
        int v;
        bit bs;
        sat = 1'b0;
        for (int l = 0; l < NB; l++) begin
            for (int c = 0; c < 2; c++) begin
                v = model_comp(d[l][c], s, bs);
                o[l][c] = v[15:0];
                sat = sat | bs;
            end
        end
        return o;
    endfunction

    function automatic idata_t fill(input logic [31:0] re, input logic [31:0] im);
        idata_t d;
        for (int l = 0; l < NB; l++) begin
            d[l][0] = re;
            d[l][1] = im;
        end
        return d;
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        return 32'($signed(w) >>> ($urandom % 24));
    endfunction

    initial begin
        bus.out_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_mode == 2) bus.out_tready = 1'($urandom % 2);
            else bus.out_tready = (rdy_mode == 1);
        end
    end

    // Present one beat, hold it until accepted; the expected result is queued at acceptance.
    task automatic send(input idata_t d, input bit last, input int gap);
        exp_t e;
        bit sat;
        bit done;
        repeat (gap) @(negedge clk);
        bus.in_tvalid = 1'b1;
        bus.in_tdata  = d;
        bus.in_tlast  = last;
        done = 1'b0;
        for (int k = 0; k < 500 && !done; k++) begin
            #2;
            if (bus.in_tready) begin
                if (!m_in_pkt) m_act = m_shift;
                m_in_pkt = !last;
                e.d   = model_beat(d, m_act, sat);
                e.last = last;
                e.cyc = cyc;
                e.lat = lat_chk;
                sbq.push_back(e);
                if (sat) m_sat++;
                if (last) m_pkt++;
                acc_cnt++;
                done = 1'b1;
            end
            @(negedge clk);
        end
        bus.in_tvalid = 1'b0;
        if (!done) begin
            $display("FAIL in_accept: beat not accepted within 500 cycles");
            $fatal(1, "input stalled");
        end
    endtask

    task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
        bus.psel = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite = 1'b1;
        bus.paddr = a;
        bus.pwdata = d;
        @(posedge clk);
        if (a == 0) begin
            m_shift = int'(d[4:0]);
            if (d[31]) begin
                m_sat = 0;
                m_pkt = 0;
            end
        end
        @(negedge clk);
        bus.penable = 1'b1;
        @(negedge clk);
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d);
        bus.paddr = a;
        #1;
        d = bus.prdata;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d beats never emerged, expected 0 pending", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_counters(input string tag);
        logic [31:0] r;
        apb_read(4'h4, r);
        check({tag, "_sat_cnt"}, 64'(r), 64'(m_sat));
        apb_read(4'h8, r);
        check({tag, "_pkt_cnt"}, 64'(r[31:8]), 64'(m_pkt % (1 << 24)));
        check({tag, "_state"}, 64'(r[0]), 64'(m_in_pkt));
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        exp_t e;
        bit stall_prev;
        odata_t prev_d;
        logic prev_l;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (stall_prev) begin
                    check("stall_valid", 64'(bus.out_tvalid), 64'd1);
                    check("stall_data", 64'(bus.out_tdata), 64'(prev_d));
                    check("stall_last", 64'(bus.out_tlast), 64'(prev_l));
                end
                if (bus.out_tvalid && bus.out_tready) begin
                    if (sbq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_beat: got data 0x%0h, expected no beat", bus.out_tdata);
                    end else begin
                        e = sbq.pop_front();
                        check("out_tdata", 64'(bus.out_tdata), 64'(e.d));
                        check("out_tlast", 64'(bus.out_tlast), 64'(e.last));
                        if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd2);
                    end
                end
                stall_prev = bus.out_tvalid && !bus.out_tready;
                prev_d = bus.out_tdata;
                prev_l = bus.out_tlast;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        int base;
        int len;
        bus.in_tvalid = 1'b0;
        bus.in_tlast = 1'b0;
        bus.in_tdata = '0;
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite = 1'b0;
        bus.paddr = '0;
        bus.pwdata = '0;
        repeat (3) @(negedge clk);
        check("rst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        check("rst_out_tlast", 64'(bus.out_tlast), 64'd0);
        check("rst_out_tdata", 64'(bus.out_tdata), 64'd0);
        check("rst_in_tready", 64'(bus.in_tready), 64'd1);
        apb_read(4'h0, r); check("rst_config", 64'(r), 64'd0);
        apb_read(4'h4, r); check("rst_sat_cnt", 64'(r), 64'd0);
        apb_read(4'h8, r); check("rst_status", 64'(r), 64'd0);
        apb_read(4'hC, r); check("unmapped_read", 64'(r), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Rounding and format.
        lat_chk = 1;
        apb_write(4'h0, 32'd15);
        apb_read(4'h0, r); check("config_rb", 64'(r), 64'd15);
        send(fill(32'h0000_4000, 32'hFFFF_C000), 1'b1, 0);
        drain(); check_counters("round");

        // Saturation on Re only.
        send(fill(32'h3FFF_FFFF, 32'hC000_0000), 1'b1, 0);
        drain(); check_counters("sat");

        // Shift 0, both components clamp, counted once.
        apb_write(4'h0, 32'd0);
        apb_write(4'hC, 32'h8000_001F);
        send(fill(32'h0001_0000, 32'hFFFE_FFFF), 1'b1, 0);
        drain(); check_counters("shift0");

        // Backpressure with ramp data.
        lat_chk = 0;
        apb_write(4'h0, 32'd3);
        rdy_mode = 2;
        for (int k = 0; k < 8; k++) begin
            idata_t d;
            for (int l = 0; l < NB; l++) begin
                d[l][0] = 32'((k - 4) * 131072 + l * 77);
                d[l][1] = 32'(-(k * 4096) - l);
            end
            send(d, k == 7, int'($urandom % 2));
        end
        drain(); rdy_mode = 1; @(negedge clk); check_counters("bp");

        // Shift latch: CONFIG write during beat 3 of a 6-beat packet.
        lat_chk = 1;
        apb_write(4'h0, 32'd15);
        base = acc_cnt;
        fork
            begin
                for (int k = 1; k <= 6; k++)
                    send(fill(32'(k * 32'h0010_0000), 32'(-(k * 32768))), k == 6, 0);
            end
            begin
                wait (acc_cnt >= base + 1);
                @(negedge clk);
                apb_read(4'h8, r);
                check("status_mid_pkt", 64'(r[0]), 64'd1);
                wait (acc_cnt >= base + 2);
                @(negedge clk);
                apb_write(4'h0, 32'd4);
            end
        join
        send(fill(32'h0000_0100, 32'hFFFF_FF00), 1'b0, 0);
        send(fill(32'h0010_0000, 32'h0000_0031), 1'b1, 0);
        drain(); check_counters("latch");

        // Randomized packets, shifts, gaps and backpressure.
        lat_chk = 0;
        rdy_mode = 2;
        for (int p = 0; p < 8; p++) begin
            apb_write(4'h0, 32'($urandom % 32));
            len = 1 + int'($urandom % 5);
            for (int k = 0; k < len; k++) begin
                idata_t d;
                for (int l = 0; l < NB; l++) begin
                    d[l][0] = rnd_word();
                    d[l][1] = rnd_word();
                end
                send(d, k == len - 1, int'($urandom % 3));
            end
        end
        drain(); rdy_mode = 1; @(negedge clk); check_counters("rand");

        // Counter clear as a saturating beat enters S2, then reset mid-packet.
        lat_chk = 1;
        apb_write(4'h0, 32'd15);
        send(fill(32'h3FFF_FFFF, 32'h0000_0000), 1'b0, 0);
        apb_write(4'h0, 32'h8000_000F);
        apb_read(4'h4, r); check("clr_sat_cnt", 64'(r), 64'd0);
        apb_read(4'h8, r); check("clr_status", 64'(r), 64'd1);
        lat_chk = 0;
        rdy_mode = 0;
        @(negedge clk);
        send(fill(32'h0000_1000, 32'h0000_2000), 1'b0, 0);
        send(fill(32'h0000_3000, 32'h0000_4000), 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        apb_read(4'h8, r); check("midrst_status", 64'(r), 64'd0);
        sbq.delete();
        m_in_pkt = 0;
        m_shift = 0;
        m_sat = 0;
        m_pkt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        @(negedge clk);
        lat_chk = 1;
        for (int k = 0; k < 4; k++)
            send(fill(32'(k * 100 - 150), 32'(1234 + k)), k == 3, 0);
        drain(); check_counters("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wfunc_out_scaler.md
# wfunc_out_scaler

Rescales the 32-bit complex products leaving the window-function stage back to 16-bit samples for the FFT core. The block applies a programmable arithmetic right shift with round-half-up, then saturates each component. It sits directly downstream of the windowing block's AXI-Stream output and is configured over the same APB bus. A small per-packet FSM latches the shift amount at packet start so a packet is never scaled inconsistently.

## Interface

Parameters:
- BUS_NUM, 2: parallel complex lanes per beat (>=2, matches upstream).
- APB_AW, 4: APB address width; registers at 0x0, 0x4, 0x8.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous, active-low.
- in_tvalid  in  1  upstream AXIS valid.
- in_tready  out  1  upstream AXIS ready.
- in_tlast  in  1  last beat of packet.
- in_tdata  in  [BUS_NUM-1:0][1:0][31:0]  per lane: index 1 = Im, index 0 = Re, signed.
- out_tvalid  out  1  downstream AXIS valid.
- out_tready  in  1  downstream AXIS ready.
- out_tlast  out  1  last beat of packet.
- out_tdata  out  [BUS_NUM-1:0][1:0][15:0]  per lane: index 1 = Im, index 0 = Re, signed.
- psel, penable, pwrite  in  1  APB controls.
- paddr  in  APB_AW  byte address; bits [1:0] are always 0.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data, combinational from paddr.

## Operation

- **Registers.** An access occurs on psel & !penable (setup phase).
  - 0x0 CONFIG: [4:0] RW shift, reset 0. [31] WO, reads 0; writing 1 clears both counters.
  - 0x4 SAT_CNT: RO. Count of beats in which at least one component saturated. Sticks at 0xFFFF_FFFF.
  - 0x8 STATUS: [31:8] RO pkt_cnt, the number of out_tlast handshakes, wraps modulo 2^24. [0] RO state (0 = IDLE, 1 = PKT).
  - Unmapped addresses read 0; writes to them are ignored.
- **FSM.**
  - IDLE: on an accepted beat, load shift_act <= CONFIG.shift. If the beat has in_tlast=0, go to PKT; otherwise stay in IDLE.
  - PKT: on an accepted beat with in_tlast=1, go to IDLE.
  - CONFIG writes during PKT take effect from the next packet.
  - The beat that loads shift_act is itself processed with the newly loaded value, via a bypass mux.
- **Arithmetic, per component x (s32), shift s:**
  - r = sign-extend(x, 33) + (s>0 ? 2^(s-1) : 0).
  - y = r >>> s (arithmetic).
  - out = clamp(y, -32768, 32767). A beat is counted as saturated if any clamp is active.
- **Pipeline.**
  - Stage 1 (S1) registers the rounded and shifted 33-bit values plus valid and last.
  - Stage 2 (S2) registers the saturated 16-bit values, valid, last, and the saturation flag. S2 drives the out_* ports directly.
  - en = !s2_valid | out_tready. Both stages advance only when en=1.
  - in_tready = en.
- **Counters.**
  - SAT_CNT increments when S1 moves into S2 (en & s1_valid) and the beat's saturation flag is set.
  - pkt_cnt increments on out_tvalid & out_tready & out_tlast.
  - A clear in the same cycle as an increment wins: the counter becomes 0.

## Timing

- Reset values:
  - out_tvalid=0, out_tlast=0, out_tdata=0.
  - in_tready=1.
  - All stage valids 0, state=IDLE, shift and shift_act 0, both counters 0.
  - prdata follows paddr.
- Latency: an input beat accepted in cycle n is presented on out_* in cycle n+2 if out_tready is held high.
- Throughput: 1 beat/clk with out_tready=1. No bubbles are inserted.
- Backpressure:
  - While out_tvalid=1 and out_tready=0, out_* are held stable and in_tready=0 in the same cycle (combinational).
  - Data already in S1 is not lost.
- in_tvalid is never required to stay high; beats arrive in any gap pattern.
- An in_tlast beat followed immediately by a new packet's first beat (back-to-back) loads shift_act on the second beat with no idle cycle.
- Reset asserted mid-packet:
  - The pipeline empties immediately and out_tvalid goes to 0.
  - The FSM returns to IDLE.
  - The next accepted beat is treated as a packet start.
- APB write and stream activity in the same cycle are independent. No stall is generated on either interface.

## Test plan

- **Rounding and format.** Shift=15, one beat with Re=0x0000_4000 and Im=0xFFFF_C000, tlast=1.
  - Out Re=0x0001, Im=0x0000 on cycle n+2; out_tlast=1.
  - SAT_CNT=0; pkt_cnt=1.
- **Saturation.** Shift=15, Re=0x3FFF_FFFF, Im=0xC000_0000.
  - Out Re=0x7FFF, Im=0x8000.
  - SAT_CNT=1, since only Re clamps.
- **Shift 0.** Re=0x0001_0000, Im=0xFFFE_FFFF.
  - Out Re=0x7FFF, Im=0x8000.
  - SAT_CNT increments by 1, counted once per beat.
- **Backpressure.** Send 8-beat ramp data with random out_tready at 50%.
  - Output sequence is identical to the no-stall run.
  - No beat is dropped or duplicated; out_* stay stable while stalled.
- **Shift latch.** Write shift=4 during beat 3 of a 6-beat packet.
  - Beats 3–6 still use the old shift=15.
  - The next packet's first beat uses shift 4; STATUS[0] reads 1 mid-packet.
- **Counter clear and reset.** Write CONFIG[31]=1 in the cycle a saturating beat enters S2; SAT_CNT reads 0. Then assert rst_n low mid-packet.
  - out_tvalid=0 immediately and STATUS reads 0.
  - A fresh 4-beat packet completes with pkt_cnt=1.
